// File: rtl/nz_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// nz_issue_scheduler_pkg
// Shared parameters and the state encoding for the nonzero issue scheduler.
//   NZ_INPUT_BIT_WIDTH : default bits per neuron byte
//   NZ_BYTES_OF_REG    : default neurons per register vector
//   NZ_ITER_BIT_WIDTH  : default width of a neuron position index
//   nz_state_e         : IDLE / ISSUE / DONE encoding of the scheduler FSM
// ---------------------------------------------------------------------------
package nz_issue_scheduler_pkg;

  localparam int NZ_INPUT_BIT_WIDTH = 8;
  localparam int NZ_BYTES_OF_REG    = 36;
  localparam int NZ_ITER_BIT_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } nz_state_e;

endpackage : nz_issue_scheduler_pkg

// File: rtl/nz_priority_enc.sv
// ---------------------------------------------------------------------------
// nz_priority_enc
// Purely combinational lowest-set-bit selector for the pending mask.
// Ports:
//   mask_i     : pending nonzero mask (bit i = neuron i still to issue)
//   index_o    : position of the lowest set bit (0 when mask is empty)
//   one_left_o : exactly one bit of mask is set
// ---------------------------------------------------------------------------
module nz_priority_enc #(
  parameter int MASK_W = 36,
  parameter int IDX_W  = 6
) (
  input  logic [MASK_W-1:0] mask_i,
  output logic [IDX_W-1:0]  index_o,
  output logic              one_left_o
);

  logic [MASK_W-1:0] rest;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves nothing exactly when one bit was set.
  assign rest       = mask_i & (mask_i - MASK_W'(1));
  assign one_left_o = (mask_i != '0) && (rest == '0);

endmodule : nz_priority_enc

// File: rtl/nz_issue_scheduler.sv
// ---------------------------------------------------------------------------
// nz_issue_scheduler
// Accepts a vector of neuron bytes, then issues only the nonzero bytes to a
// downstream MAC, lowest position first, one per cycle while out_ready is
// high. A done pulse marks the end of each vector (also for all-zero ones).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : neuron vector offered      in_ready : accepting (IDLE only)
//   neuron     : flat vector, byte i at [i*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH]
//   out_valid  : issue slot presented       out_ready : slot consumed
//   out_index  : position of issued byte    out_neuron : its value
//   out_last   : final nonzero of vector    done : one-cycle end pulse
//   nz_count   : (only with NZ_ISSUE_COUNT_EN) nonzeros issued in the
//                vector that just completed, valid while done=1
// Optional feature macro: NZ_ISSUE_COUNT_EN
// ---------------------------------------------------------------------------
module nz_issue_scheduler
  import nz_issue_scheduler_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = NZ_INPUT_BIT_WIDTH,
  parameter int BYTES_OF_REG    = NZ_BYTES_OF_REG,
  parameter int ITER_BIT_WIDTH  = NZ_ITER_BIT_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [BYTES_OF_REG*INPUT_BIT_WIDTH-1:0] neuron,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ITER_BIT_WIDTH-1:0]               out_index,
  output logic [INPUT_BIT_WIDTH-1:0]              out_neuron,
  output logic                                    out_last,
  output logic                                    done
`ifdef NZ_ISSUE_COUNT_EN
  ,
  output logic [ITER_BIT_WIDTH-1:0]               nz_count
`endif
);

  nz_state_e                  state_q, state_d;
  logic [BYTES_OF_REG-1:0]    mask_q, mask_d;
  logic [INPUT_BIT_WIDTH-1:0] data_q [BYTES_OF_REG];
  logic [INPUT_BIT_WIDTH-1:0] in_bytes [BYTES_OF_REG];
  logic [BYTES_OF_REG-1:0]    in_mask;
  logic [ITER_BIT_WIDTH-1:0]  enc_index;
  logic                       enc_one_left;
  logic                       accept;
  logic                       issue;

  // Split the flat input into bytes and build the nonzero mask.
  generate
    for (genvar gi = 0; gi < BYTES_OF_REG; gi++) begin : g_in
      assign in_bytes[gi] = neuron[gi*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
      assign in_mask[gi]  = (in_bytes[gi] != '0);
    end
  endgenerate

  nz_priority_enc #(
    .MASK_W (BYTES_OF_REG),
    .IDX_W  (ITER_BIT_WIDTH)
  ) u_enc (
    .mask_i     (mask_q),
    .index_o    (enc_index),
    .one_left_o (enc_one_left)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_ISSUE);
  assign done      = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;

  // Slot fields are derived from registered state only, so they cannot move
  // while the slot is stalled; they are forced to zero outside ISSUE.
  assign out_index  = out_valid ? enc_index : '0;
  assign out_neuron = out_valid ? data_q[enc_index] : '0;
  assign out_last   = out_valid && enc_one_left;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mask_d  = in_mask;
          state_d = (in_mask != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          // The issued bit is always the lowest set one.
          mask_d = mask_q & (mask_q - BYTES_OF_REG'(1));
          if (enc_one_left) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      for (int i = 0; i < BYTES_OF_REG; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (accept) begin
        for (int i = 0; i < BYTES_OF_REG; i++) begin
          data_q[i] <= in_bytes[i];
        end
      end
    end
  end

`ifdef NZ_ISSUE_COUNT_EN
  logic [ITER_BIT_WIDTH-1:0] count_q;

  // Restarts on acceptance and counts handshakes, so it holds the final
  // count during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= '0;
    end else if (issue) begin
      count_q <= count_q + ITER_BIT_WIDTH'(1);
    end
  end

  assign nz_count = count_q;
`endif

endmodule : nz_issue_scheduler

// File: tb/tb_nz_issue_scheduler.sv
module tb_nz_issue_scheduler;

  localparam int W  = 8;
  localparam int N  = 36;
  localparam int IW = 6;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] neuron;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_index;
  logic [W-1:0]   out_neuron;
  logic           out_last;
  logic           done;
`ifdef NZ_ISSUE_COUNT_EN
  logic [IW-1:0]  nz_count;
`endif

  int total;
  int bad;

  nz_issue_scheduler #(
    .INPUT_BIT_WIDTH (W),
    .BYTES_OF_REG    (N),
    .ITER_BIT_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .neuron     (neuron),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_neuron (out_neuron),
    .out_last   (out_last),
    .done       (done)
`ifdef NZ_ISSUE_COUNT_EN
    ,
    .nz_count   (nz_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; neuron = '0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 ||
        out_index !== '0 || out_neuron !== '0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b done=%b idx=%0d nrn=%h last=%b required 1 0 0 0 00 0",
               in_ready, out_valid, done, out_index, out_neuron, out_last);
    end
`ifdef NZ_ISSUE_COUNT_EN
    total++;
    if (nz_count !== '0) begin
      bad++;
      $display("FAIL reset_nz_count: got %0d required 0", nz_count);
    end
`endif
  endtask

  task automatic test_sparse();
    int exp_idx [3] = '{3, 17, 35};
    logic [7:0] exp_val [3] = '{8'h11, 8'h22, 8'h33};
    neuron = '0;
    neuron[3*W +: W] = 8'h11;
    neuron[17*W +: W] = 8'h22;
    neuron[35*W +: W] = 8'h33;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_index !== IW'(exp_idx[k]) ||
          out_neuron !== exp_val[k] || out_last !== (k == 2) || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL sparse_issue%0d: valid=%b idx=%0d nrn=%h last=%b rdy=%b required 1 %0d %h %b 0",
                 k, out_valid, out_index, out_neuron, out_last, in_ready,
                 exp_idx[k], exp_val[k], (k == 2));
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sparse_done: done=%b valid=%b required 1 0", done, out_valid);
    end
`ifdef NZ_ISSUE_COUNT_EN
    total++;
    if (nz_count !== IW'(3)) begin
      bad++;
      $display("FAIL sparse_nz_count: got %0d required 3", nz_count);
    end
`endif
    tick();
    total++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL sparse_idle: done=%b in_ready=%b required 0 1", done, in_ready);
    end
  endtask

  task automatic test_zero();
    int pulses = 0;
    int valids = 0;
    neuron = '0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: done=%b valid=%b required 1 0", done, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      pulses += int'(done);
      valids += int'(out_valid);
      tick();
    end
    total++;
    if (pulses != 1 || valids != 0) begin
      bad++;
      $display("FAIL zero_count: done_pulses=%0d valid_cycles=%0d required 1 0", pulses, valids);
    end
  endtask

  task automatic test_backpressure();
    int e = 0;
    int cyc = 0;
    for (int i = 0; i < N; i++) neuron[i*W +: W] = 8'h01;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    while (e < N && cyc < 200) begin
      total++;
      if (out_valid !== 1'b1 || out_index !== IW'(e) || out_neuron !== 8'h01 ||
          out_last !== (e == N - 1)) begin
        bad++;
        $display("FAIL bp_slot cyc=%0d: valid=%b idx=%0d nrn=%h last=%b required 1 %0d 01 %b",
                 cyc, out_valid, out_index, out_neuron, out_last, e, (e == N - 1));
      end
      out_ready = (cyc % 2 == 0);
      if (out_ready) e++;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (e != N || done !== 1'b1) begin
      bad++;
      $display("FAIL bp_end: issues=%0d done=%b required %0d 1", e, done, N);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    neuron = '0;
    for (int i = 0; i < 5; i++) neuron[(2*i)*W +: W] = 8'(8'h40 + i);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_index !== IW'(2*k)) begin
        bad++;
        $display("FAIL rstmid_issue%0d: valid=%b idx=%0d required 1 %0d", k, out_valid, out_index, 2*k);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle: in_ready=%b valid=%b done=%b required 1 0 0", in_ready, out_valid, done);
    end
    for (int k = 0; k < 4; k++) begin
      pulses += int'(done);
      tick();
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL rstmid_nodone: done_pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    neuron = '0;
    neuron[1*W +: W] = 8'hA1;
    neuron[2*W +: W] = 8'hA2;
    in_valid = 1'b1; out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_ready: got %b required 1", in_ready);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== IW'(k + 1)) begin
        bad++;
        $display("FAIL b2b_issue%0d: in_ready=%b valid=%b idx=%0d required 0 1 %0d",
                 k, in_ready, out_valid, out_index, k + 1);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: done=%b in_ready=%b required 1 0", done, in_ready);
    end
    neuron = '0;
    neuron[5*W +: W] = 8'h55;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: in_ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_index !== IW'(5) || out_neuron !== 8'h55 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: valid=%b idx=%0d nrn=%h last=%b required 1 5 55 1",
               out_valid, out_index, out_neuron, out_last);
    end
    tick();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_done: done=%b required 1", done);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; neuron = '0;
    test_reset();
    $display("test_reset done");
    test_sparse();
    $display("test_sparse done");
    test_zero();
    $display("test_zero done");
    test_backpressure();
    $display("test_backpressure done");
    test_reset_mid();
    $display("test_reset_mid done");
    test_back_to_back();
    $display("test_back_to_back done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nz_issue_scheduler

// File: doc/nz_issue_scheduler.md
NZ_ISSUE_SCHEDULER -- requirements
Module: nz_issue_scheduler

Interface
REQ-001 SHALL take parameter INPUT_BIT_WIDTH, default 8, meaning bits per neuron byte.
REQ-002 SHALL take parameter BYTES_OF_REG, default 36, meaning neurons per register vector.
REQ-003 SHALL take parameter ITER_BIT_WIDTH, default 6, meaning width of a neuron position index.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, a neuron vector is offered.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a vector.
REQ-008 SHALL have port neuron, input, BYTES_OF_REG x INPUT_BIT_WIDTH, the offered neuron vector.
REQ-009 SHALL have port out_valid, output, 1, an issue slot is presented.
REQ-010 SHALL have port out_ready, input, 1, the downstream MAC consumes the slot.
REQ-011 SHALL have port out_index, output, ITER_BIT_WIDTH, position of the issued nonzero neuron.
REQ-012 SHALL have port out_neuron, output, INPUT_BIT_WIDTH, value of the issued neuron.
REQ-013 SHALL have port out_last, output, 1, the slot is the final nonzero of the vector.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a vector is fully processed.

Function
REQ-015 SHALL implement states IDLE, ISSUE and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL, on in_valid&&in_ready, capture neuron and set pending mask bit i = (neuron[i]!=0).
REQ-018 SHALL move IDLE->ISSUE when the captured mask is nonzero, else IDLE->DONE.
REQ-019 SHALL, in ISSUE, drive out_valid=1, out_index = lowest set pending bit, and out_neuron = captured neuron[out_index].
REQ-020 SHALL drive out_last=1 when exactly one pending bit remains.
REQ-021 SHALL hold out_index, out_neuron and out_last stable while out_valid&&!out_ready.
REQ-022 SHALL, on out_valid&&out_ready, clear the issued bit; it moves ISSUE->DONE if out_last, else stays in ISSUE.
REQ-023 SHALL give first-issue latency of one cycle after acceptance, and a throughput of one nonzero per cycle with out_ready held high.
REQ-024 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-025 SHALL keep out_valid=0 in IDLE and DONE; out_index, out_neuron and out_last are 0 when out_valid=0.
REQ-026 SHALL issue indices in strictly ascending order, with no index issued twice per vector.
REQ-027 SHALL, for an all-zero vector, issue nothing and pulse done on the cycle after acceptance.

Reset
REQ-028 SHALL, on rst, force IDLE, a zero mask and zero captured data; in_ready=1 and all other outputs 0 on the first cycle after reset.
REQ-029 SHALL, on rst in any state, abandon the current vector and produce no done pulse.
REQ-030 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-031 SHALL, when NZ_ISSUE_COUNT_EN is defined, add output nz_count of width ITER_BIT_WIDTH, holding the number of nonzeros in the last completed vector and valid while done=1.
REQ-032 SHALL reset nz_count to 0 when NZ_ISSUE_COUNT_EN is defined.
REQ-033 SHALL, without NZ_ISSUE_COUNT_EN, have neither the port nz_count nor its counter, and otherwise behave identically.

Structure
REQ-034 SHALL take INPUT_BIT_WIDTH, BYTES_OF_REG, ITER_BIT_WIDTH and the state encoding from the shared parameter package.
REQ-035 SHALL place lowest-set-bit selection in sub-module nz_priority_enc (mask in; index and one-left flag out).

Verification
REQ-036 SHALL verify a sparse vector: neuron[3]=0x11, neuron[17]=0x22, neuron[35]=0x33, rest 0, out_ready=1 -> out_index 3,17,35 on consecutive cycles with out_neuron 0x11,0x22,0x33, out_last on index 35, then done one cycle later.
REQ-037 SHALL verify an all-zero vector -> no out_valid, and done pulses exactly once, one cycle after acceptance.
REQ-038 SHALL verify backpressure: dense vector (all 36 bytes 0x01) with out_ready toggling 1,0,1,0 -> 36 issues, indices 0..35, and outputs stable during stalls.
REQ-039 SHALL verify reset mid-vector: rst asserted after 2 of 5 issues -> IDLE next cycle, in_ready=1, and no done pulse.
REQ-040 SHALL verify back-to-back vectors: in_valid held high -> second vector accepted only after done, with in_ready=0 throughout ISSUE.
REQ-041 SHALL verify, with NZ_ISSUE_COUNT_EN defined, the REQ-036 vector -> nz_count=3 while done=1.
